// File: rtl/wide_issue_queue.sv
// Multi-lane circular issue queue: up to PUSH_W in-order pushes and POP_W pops per cycle.
// Define IQ_ERR_CHECK_EN to build the sticky misuse detector that drives err.
module wide_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int PUSH_W  = 4,
  parameter int POP_W   = 2,
  parameter int ENTRY_W = 64,
  localparam int CW  = $clog2(DEPTH + 1),
  localparam int PNW = $clog2(PUSH_W + 1),
  localparam int QNW = $clog2(POP_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [PNW-1:0]              push_num,
  input  logic [PUSH_W*ENTRY_W-1:0]   push_data,
  output logic                        push_ready,
  input  logic [QNW-1:0]              pop_num,
  output logic [POP_W*ENTRY_W-1:0]    head_data,
  output logic [POP_W-1:0]            head_valid,
  output logic [CW-1:0]               count,
  output logic [CW-1:0]               free,
  output logic                        err
);

  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] storage_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      free_w;
  logic [CW-1:0]      push_num_ext;
  logic [CW-1:0]      pop_num_ext;
  logic [CW-1:0]      eff_pop;
  logic               push_ok;
  logic               wr_en;
  logic [PUSH_W-1:0]  lane_we;
  logic [PW-1:0]      lane_idx [PUSH_W];

  assign free_w       = CW'(DEPTH) - count_q;
  assign push_num_ext = CW'(push_num);
  assign pop_num_ext  = CW'(pop_num);

  // Space check sees only the start-of-cycle occupancy; pops never lend credit.
  assign push_ok    = (push_num_ext <= free_w);
  assign push_ready = push_ok;
  assign eff_pop    = (pop_num_ext > count_q) ? count_q : pop_num_ext;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(eff_pop);
      count_d  = count_q - eff_pop;
      if (push_ok) begin
        wr_en    = (push_num_ext != '0);
        wr_ptr_d = wr_ptr_q + PW'(push_num);
        count_d  = count_q - eff_pop + push_num_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Per-lane write decode; indices wrap naturally in PW bits.
  for (genvar gi = 0; gi < PUSH_W; gi++) begin : g_push_lane
    assign lane_we[gi]  = wr_en && (PNW'(gi) < push_num);
    assign lane_idx[gi] = wr_ptr_q + PW'(gi);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (lane_we[i]) begin
        storage_q[lane_idx[i]] <= push_data[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  for (genvar gi = 0; gi < POP_W; gi++) begin : g_head_lane
    logic [PW-1:0] idx;
    assign idx            = rd_ptr_q + PW'(gi);
    assign head_valid[gi] = (CW'(gi) < count_q);
    assign head_data[gi*ENTRY_W +: ENTRY_W] = head_valid[gi] ? storage_q[idx] : '0;
  end

  assign count = count_q;
  assign free  = free_w;

`ifdef IQ_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!flush && (!push_ok || (pop_num_ext > count_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
